// File: rtl/binop_response_checker.sv
// binop_response_checker: scores a run of NUM_VECTORS vectors of 8 binary-op results against
// internally computed expectations, reporting mismatch count and the first failing vector.
module binop_response_checker #(
    parameter int WIDTH       = 1,
    parameter int NUM_VECTORS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [8*WIDTH-1:0] res,
    output logic [7:0]         mismatch_cnt,
    output logic [7:0]         first_err_idx,
    output logic [7:0]         first_err_mask,
    output logic               err_seen,
    output logic               done,
    output logic               pass
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0] state_q, state_d;
    logic [7:0] idx_q, idx_d, cmp_idx_q, cmp_idx_d, cmp_mask_q, cmp_mask_d;
    logic [7:0] cnt_q, cnt_d, eidx_q, eidx_d, emask_q, emask_d;
    logic       cmp_vld_q, err_q, err_d;
    logic [WIDTH-1:0] expv [8];
    logic accept, clr, bad, first_hit;
    assign in_ready  = state_q == RUN;
    assign accept    = in_valid && in_ready;
    assign clr       = start && (state_q == IDLE || state_q == DONE);
    assign bad       = cmp_vld_q && |cmp_mask_q;
    assign first_hit = bad && !err_q;
    always_comb begin
        expv[0] = a & b;
        expv[1] = a | b;
        expv[2] = a ^ b;
        expv[3] = ~(a ^ b);
        expv[4] = WIDTH'(a < b);
        expv[5] = WIDTH'(a == b);
        expv[6] = a + b;
        expv[7] = a - b;
        cmp_mask_d = '0;
        // 4-state compare so X/Z on a result slot is flagged
        for (int s = 0; s < 8; s++) cmp_mask_d[s] = res[s*WIDTH +: WIDTH] !== expv[s];
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (accept && idx_q == 8'(NUM_VECTORS - 1)) ? DRAIN : RUN;
            DRAIN:   state_d = DONE;
            default: state_d = start ? RUN : DONE;
        endcase
    end
    assign idx_d     = clr ? '0 : accept ? idx_q + 8'd1 : idx_q;
    assign cmp_idx_d = accept ? idx_q : cmp_idx_q;
    assign cnt_d     = clr ? '0 : (bad && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    assign eidx_d    = clr ? '0 : first_hit ? cmp_idx_q : eidx_q;
    assign emask_d   = clr ? '0 : first_hit ? cmp_mask_q : emask_q;
    assign err_d     = clr ? 1'b0 : err_q || bad;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
            cmp_mask_q <= '0;
            cnt_q      <= '0;
            eidx_q     <= '0;
            emask_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmp_vld_q  <= accept;
            cmp_idx_q  <= cmp_idx_d;
            cmp_mask_q <= accept ? cmp_mask_d : cmp_mask_q;
            cnt_q      <= cnt_d;
            eidx_q     <= eidx_d;
            emask_q    <= emask_d;
            err_q      <= err_d;
        end
    end
    assign mismatch_cnt   = cnt_q;
    assign first_err_idx  = eidx_q;
    assign first_err_mask = emask_q;
    assign err_seen       = err_q;
    assign done           = state_q == DONE;
    assign pass           = done && cnt_q == 8'd0;
endmodule

// File: tb/tb_binop_response_checker.sv
// tb_binop_response_checker: scoreboard bench driving a WIDTH=1/NUM_VECTORS=4 and a
// WIDTH=4/NUM_VECTORS=2 checker; expected run results come from an arithmetic reference model.
module tb_binop_response_checker;
    typedef struct {
        logic [7:0] cnt, idx, mask;
        logic       err, pass;
    } resp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic s1 = 0, v1 = 0, rdy1, err1, done1, pass1;
    logic [0:0] a1 = '0, b1 = '0;
    logic [7:0] r1 = '0, cnt1, idx1, mask1;
    logic s4 = 0, v4 = 0, rdy4, err4, done4, pass4;
    logic [3:0] a4 = '0, b4 = '0;
    logic [31:0] r4 = '0;
    logic [7:0] cnt4, idx4, mask4;
    logic pd1 = 0, pd4 = 0;
    int n_chk = 0, n_fail = 0;
    resp_t sb0[$], sb4[$];
    int qa[$], qb[$];
    logic [31:0] qr[$];
    always #5 clk = ~clk;
    binop_response_checker #(.WIDTH(1), .NUM_VECTORS(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1),
        .res(r1), .mismatch_cnt(cnt1), .first_err_idx(idx1), .first_err_mask(mask1),
        .err_seen(err1), .done(done1), .pass(pass1));
    binop_response_checker #(.WIDTH(4), .NUM_VECTORS(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .in_valid(v4), .in_ready(rdy4), .a(a4), .b(b4),
        .res(r4), .mismatch_cnt(cnt4), .first_err_idx(idx4), .first_err_mask(mask4),
        .err_seen(err4), .done(done4), .pass(pass4));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int slot_val(input int w, input int s, input int a, input int b);
        int v;
        v = s == 0 ? a & b : s == 1 ? a | b : s == 2 ? a ^ b : s == 3 ? ~(a ^ b) :
            s == 4 ? int'(a < b) : s == 5 ? int'(a == b) : s == 6 ? a + b : a - b;
        return v & ((1 << w) - 1);
    endfunction
    function automatic logic [7:0] vec_mask(input int w, input int a, input int b, input logic [31:0] r);
        logic [7:0] m = '0;
        for (int s = 0; s < 8; s++)
            for (int j = 0; j < w; j++)
                if (r[s*w+j] !== 1'((slot_val(w, s, a, b) >> j) & 1)) m[s] = 1'b1;
        return m;
    endfunction
    task automatic add_vec(input int w, input int a, input int b, input logic [31:0] xm, input logic [31:0] xz);
        logic [31:0] r = '0;
        for (int s = 0; s < 8; s++) r |= 32'(slot_val(w, s, a, b)) << (s * w);
        r ^= xm;
        for (int j = 0; j < 32; j++) if (xz[j]) r[j] = 1'bx;
        qa.push_back(a);
        qb.push_back(b);
        qr.push_back(r);
    endtask
    task automatic drive(input int d, input logic st, input logic v, input int a, input int b, input logic [31:0] r);
        if (d == 0) begin
            s1 = st; v1 = v; a1 = 1'(a); b1 = 1'(b); r1 = r[7:0];
        end else begin
            s4 = st; v4 = v; a4 = 4'(a); b4 = 4'(b); r4 = r;
        end
    endtask
    function automatic logic rdy_of(input int d);
        return d == 0 ? rdy1 : rdy4;
    endfunction
    function automatic logic done_of(input int d);
        return d == 0 ? done1 : done4;
    endfunction
    // Issues one run from the queued vectors; a full run pushes its modelled outcome.
    task automatic play(input int d, input int n_send, input int stall_at, input int stall_len, input bit start_mid);
        int w = d == 0 ? 1 : 4;
        int nv = d == 0 ? 4 : 2;
        resp_t e = '{cnt: 0, idx: 0, mask: 0, err: 0, pass: 0};
        logic [7:0] m;
        for (int i = 0; i < n_send; i++) begin
            m = vec_mask(w, qa[i], qb[i], qr[i]);
            if (m != 0) begin
                if (!e.err) begin e.idx = 8'(i); e.mask = m; e.err = 1; end
                if (e.cnt != 8'hFF) e.cnt++;
            end
        end
        e.pass = e.cnt == 0;
        if (n_send == nv) begin
            if (d == 0) sb0.push_back(e); else sb4.push_back(e);
        end
        drive(d, 1, 0, 0, 0, 0);
        for (int i = 0; i < n_send; i++) begin
            @(negedge clk);
            if (i == stall_at)
                repeat (stall_len) begin
                    drive(d, 0, 0, 0, 0, 0);
                    chk("stall_in_ready", 32'(rdy_of(d)), 1);
                    chk("stall_done", 32'(done_of(d)), 0);
                    @(negedge clk);
                end
            chk("run_in_ready", 32'(rdy_of(d)), 1);
            drive(d, start_mid && i == 1, 1, qa[i], qb[i], qr[i]);
        end
        if (n_send == nv) begin
            @(negedge clk);
            drive(d, 0, 0, 0, 0, 0);
            chk("drain_done", 32'(done_of(d)), 0);
            chk("drain_in_ready", 32'(rdy_of(d)), 0);
            @(negedge clk);
            chk("done_two_after_last", 32'(done_of(d)), 1);
        end
        qa.delete(); qb.delete(); qr.delete();
    endtask
    task automatic mon_chk(input int d, input resp_t e);
        string p = d == 0 ? "w1" : "w4";
        chk({p, "_mismatch_cnt"}, d == 0 ? cnt1 : cnt4, e.cnt);
        chk({p, "_first_err_idx"}, d == 0 ? idx1 : idx4, e.idx);
        chk({p, "_first_err_mask"}, d == 0 ? mask1 : mask4, e.mask);
        chk({p, "_err_seen"}, d == 0 ? err1 : err4, e.err);
        chk({p, "_pass"}, d == 0 ? pass1 : pass4, e.pass);
    endtask
    always @(negedge clk) begin
        if (done1 && !pd1) begin
            if (sb0.size() == 0) chk("w1_unexpected_done", 1, 0); else mon_chk(0, sb0.pop_front());
        end
        if (done4 && !pd4) begin
            if (sb4.size() == 0) chk("w4_unexpected_done", 1, 0); else mon_chk(1, sb4.pop_front());
        end
        pd1 <= done1;
        pd4 <= done4;
    end
    task automatic chk_zero(input string nm);
        chk({nm, "_w1_outs"}, {rdy1, done1, pass1, err1, cnt1, idx1, mask1}, 0);
        chk({nm, "_w4_outs"}, {rdy4, done4, pass4, err4, cnt4, idx4, mask4}, 0);
    endtask
    initial begin
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1;
        @(negedge clk) chk_zero("idle_after_release");
        for (int i = 0; i < 4; i++) add_vec(1, i >> 1, i & 1, 0, 0);
        play(0, 4, -1, 0, 0);
        for (int i = 0; i < 4; i++) add_vec(1, i >> 1, i & 1, i == 2 ? 32'h40 : 0, 0);
        play(0, 4, -1, 0, 1);
        for (int i = 0; i < 4; i++) add_vec(1, i >> 1, i & 1, i == 3 ? 32'h14 : 0, i == 1 ? 32'h20 : 0);
        play(0, 4, -1, 0, 0);
        for (int i = 0; i < 4; i++) add_vec(1, i >> 1, i & 1, 0, 0);
        play(0, 4, 2, 3, 0);
        for (int i = 0; i < 4; i++) add_vec(1, i >> 1, i & 1, i >= 1 ? 32'h01 : 0, 0);
        play(0, 3, -1, 0, 0);
        @(posedge clk);
        #1 chk("pre_reset_cnt", cnt1, 1);
        rst_n = 0;
        #1 chk_zero("mid_run_reset");
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1;
        repeat (3) begin
            drive(0, 0, 1, 1, 0, 0);
            @(negedge clk);
            chk("no_start_in_ready", 32'(rdy1), 0);
            chk("no_start_cnt", cnt1, 0);
            chk("no_start_done", 32'(done1), 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add_vec(1, i >> 1, i & 1, 0, 0);
        play(0, 4, -1, 0, 0);
        add_vec(4, 15, 1, 0, 0);
        add_vec(4, 0, 1, 0, 0);
        play(1, 2, -1, 0, 0);
        for (int r = 0; r < 24; r++) begin
            int d = r % 2;
            int w = d == 0 ? 1 : 4;
            for (int i = 0; i < (d == 0 ? 4 : 2); i++)
                add_vec(w, $urandom_range(0, (1 << w) - 1), $urandom_range(0, (1 << w) - 1),
                        $urandom_range(0, 2) == 0 ? 32'(1) << $urandom_range(0, 8 * w - 1) : 0, 0);
            play(d, d == 0 ? 4 : 2, $urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        chk("w1_scoreboard_drained", sb0.size(), 0);
        chk("w4_scoreboard_drained", sb4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
